// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-master memory bus arbiter.
package mem_arb_pkg;

  // Arbiter FSM: grant in IDLE, hold the bus in ACCESS, pulse done in DONE.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Master indices as carried on grant / last_grant.
  localparam logic M_CPU = 1'b0;
  localparam logic M_DMA = 1'b1;

  // Active-low write mask with no byte lane enabled; slice to the mask width.
  localparam logic [127:0] MASK_ALL_OFF = '1;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational 2-way round-robin pick: on a tie the master that did not
// win last time is chosen; a lone requester always wins.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       valid
);

  // Tie goes to the master opposite last_grant, otherwise to whoever asks.
  always_comb begin
    valid = |req;
    grant = M_CPU;
    if (req == 2'b11) begin
      grant = ~last_grant;
    end else if (req[1]) begin
      grant = M_DMA;
    end
  end

endmodule

// File: rtl/memory_bus_arbiter.sv
// Shares one memory bus between the CPU (master 0) and DMA (master 1).
// One transaction at a time: the winner's request is latched onto the bus
// outputs, held for BUS_LATENCY clocks, then done pulses for one clock.
module memory_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int BUS_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    m0_req,
  input  logic                    m0_we,
  input  logic [ADDR_WIDTH-1:0]   m0_addr,
  input  logic [DATA_WIDTH-1:0]   m0_wdata,
  input  logic [DATA_WIDTH/8-1:0] m0_wmask,
  output logic                    m0_done,
  input  logic                    m1_req,
  input  logic                    m1_we,
  input  logic [ADDR_WIDTH-1:0]   m1_addr,
  input  logic [DATA_WIDTH-1:0]   m1_wdata,
  input  logic [DATA_WIDTH/8-1:0] m1_wmask,
  output logic                    m1_done,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [ADDR_WIDTH-1:0]   bus_address,
  output logic [DATA_WIDTH-1:0]   bus_data_in,
  output logic [DATA_WIDTH/8-1:0] bus_write_mask,
  output logic                    bus_enable,
  output logic                    bus_write_enable,
  input  logic [DATA_WIDTH-1:0]   bus_data_out
);

  localparam int MW = DATA_WIDTH / 8;
  // Counter only ever holds BUS_LATENCY-1 down to 0.
  localparam int CW = (BUS_LATENCY > 1) ? $clog2(BUS_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(BUS_LATENCY - 1);
  localparam logic [MW-1:0] MASK_OFF = MASK_ALL_OFF[MW-1:0];

  state_t          state_reg;
  state_t          state_next;
  logic [CW-1:0]   cnt_reg;
  logic            grant_reg;
  logic            last_grant_reg;

  logic            pick_grant;
  logic            pick_valid;

  rr_arbiter2 u_rr (
    .req        ({m1_req, m0_req}),
    .last_grant (last_grant_reg),
    .grant      (pick_grant),
    .valid      (pick_valid)
  );

  // Request fields of the current winner, captured only at grant time.
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [MW-1:0]         sel_wmask;

  assign sel_we    = (pick_grant == M_DMA) ? m1_we    : m0_we;
  assign sel_addr  = (pick_grant == M_DMA) ? m1_addr  : m0_addr;
  assign sel_wdata = (pick_grant == M_DMA) ? m1_wdata : m0_wdata;
  assign sel_wmask = (pick_grant == M_DMA) ? m1_wmask : m0_wmask;

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state: leave IDLE on any request, leave ACCESS when the count expires.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (pick_valid) state_next = ST_ACCESS;
      ST_ACCESS: if (cnt_reg == '0) state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Bus drive, latency counter, read capture and done pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg          <= '0;
      grant_reg        <= M_CPU;
      last_grant_reg   <= M_DMA;
      m0_done          <= 1'b0;
      m1_done          <= 1'b0;
      rdata            <= '0;
      bus_address      <= '0;
      bus_data_in      <= '0;
      bus_write_mask   <= MASK_OFF;
      bus_enable       <= 1'b0;
      bus_write_enable <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (pick_valid) begin
            bus_address      <= sel_addr;
            bus_data_in      <= sel_wdata;
            bus_write_mask   <= sel_wmask;
            bus_enable       <= 1'b1;
            bus_write_enable <= sel_we;
            cnt_reg          <= CNT_LOAD;
            grant_reg        <= pick_grant;
          end
        end
        ST_ACCESS: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - CW'(1);
          end else begin
            if (!bus_write_enable) begin
              rdata <= bus_data_out;
            end
            bus_enable       <= 1'b0;
            bus_write_enable <= 1'b0;
            m0_done          <= (grant_reg == M_CPU);
            m1_done          <= (grant_reg == M_DMA);
            last_grant_reg   <= grant_reg;
          end
        end
        ST_DONE: begin
          m0_done <= 1'b0;
          m1_done <= 1'b0;
        end
        default: begin
          m0_done <= 1'b0;
          m1_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed bench for memory_bus_arbiter: one DUT at BUS_LATENCY=2 and a
// second at BUS_LATENCY=1 sharing the same master inputs.
module tb_memory_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [15:0] m0_addr = '0;
  logic [31:0] m0_wdata = '0;
  logic [3:0]  m0_wmask = 4'hF;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [15:0] m1_addr = '0;
  logic [31:0] m1_wdata = '0;
  logic [3:0]  m1_wmask = 4'hF;
  logic [31:0] bus_data_out = '0;

  logic        m0_done, m1_done, bus_enable, bus_write_enable;
  logic [31:0] rdata, bus_data_in;
  logic [15:0] bus_address;
  logic [3:0]  bus_write_mask;

  logic        d1_m0_done, d1_m1_done, d1_bus_enable, d1_bus_write_enable;
  logic [31:0] d1_rdata, d1_bus_data_in;
  logic [15:0] d1_bus_address;
  logic [3:0]  d1_bus_write_mask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  memory_bus_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .BUS_LATENCY(2)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wmask(m0_wmask), .m0_done(m0_done),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wmask(m1_wmask), .m1_done(m1_done),
    .rdata(rdata), .bus_address(bus_address), .bus_data_in(bus_data_in),
    .bus_write_mask(bus_write_mask), .bus_enable(bus_enable),
    .bus_write_enable(bus_write_enable), .bus_data_out(bus_data_out)
  );

  memory_bus_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .BUS_LATENCY(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wmask(m0_wmask), .m0_done(d1_m0_done),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wmask(m1_wmask), .m1_done(d1_m1_done),
    .rdata(d1_rdata), .bus_address(d1_bus_address), .bus_data_in(d1_bus_data_in),
    .bus_write_mask(d1_bus_write_mask), .bus_enable(d1_bus_enable),
    .bus_write_enable(d1_bus_write_enable), .bus_data_out(bus_data_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to just after the next active edge; used for both driving and sampling.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  int d0, d1, n;
  int order[6];
  int when[6];

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- Reset values ----
    tick();
    check("rst_bus_enable", {31'd0, bus_enable}, 32'd0);
    check("rst_bus_we", {31'd0, bus_write_enable}, 32'd0);
    check("rst_mask", {28'd0, bus_write_mask}, 32'h0000_000F);
    check("rst_rdata", rdata, 32'd0);
    check("rst_addr", {16'd0, bus_address}, 32'd0);
    check("rst_done", {30'd0, m1_done, m0_done}, 32'd0);
    check("rst_d1_mask", {28'd0, d1_bus_write_mask}, 32'h0000_000F);
    reset_n = 1'b1;
    tick();

    // ---- m0 read 0x4000, memory returns 0x12345678 ----
    bus_data_out = 32'h1234_5678;
    m0_we = 1'b0; m0_addr = 16'h4000; m0_req = 1'b1;
    tick(); // clock 1: granted
    check("rd_en_c1", {31'd0, bus_enable}, 32'd1);
    check("rd_we_c1", {31'd0, bus_write_enable}, 32'd0);
    check("rd_addr_c1", {16'd0, bus_address}, 32'h0000_4000);
    check("rd_done_c1", {31'd0, m0_done}, 32'd0);
    check("l1_en_c1", {31'd0, d1_bus_enable}, 32'd1);
    tick(); // clock 2
    check("rd_en_c2", {31'd0, bus_enable}, 32'd1);
    check("rd_done_c2", {31'd0, m0_done}, 32'd0);
    check("l1_done_c2", {31'd0, d1_m0_done}, 32'd1);
    check("l1_en_c2", {31'd0, d1_bus_enable}, 32'd0);
    check("l1_rdata", d1_rdata, 32'h1234_5678);
    tick(); // clock 3: done
    check("rd_en_c3", {31'd0, bus_enable}, 32'd0);
    check("rd_done_c3", {31'd0, m0_done}, 32'd1);
    check("rd_m1_done_c3", {31'd0, m1_done}, 32'd0);
    check("rd_rdata", rdata, 32'h1234_5678);
    m0_req = 1'b0;
    $display("txn m0 read addr=4000 rdata=%h", rdata);
    tick();
    check("rd_done_c4", {31'd0, m0_done}, 32'd0);

    // ---- m1 write 0x0010 ----
    bus_data_out = 32'hDEAD_BEEF;
    m1_we = 1'b1; m1_addr = 16'h0010; m1_wdata = 32'hAABB_CCDD; m1_wmask = 4'b1110;
    m1_req = 1'b1;
    tick();
    check("wr_we_c1", {31'd0, bus_write_enable}, 32'd1);
    check("wr_mask_c1", {28'd0, bus_write_mask}, 32'h0000_000E);
    check("wr_data_c1", bus_data_in, 32'hAABB_CCDD);
    check("wr_addr_c1", {16'd0, bus_address}, 32'h0000_0010);
    tick();
    check("wr_we_c2", {31'd0, bus_write_enable}, 32'd1);
    check("wr_mask_c2", {28'd0, bus_write_mask}, 32'h0000_000E);
    tick();
    check("wr_done", {30'd0, m1_done, m0_done}, 32'd2);
    check("wr_rdata_kept", rdata, 32'h1234_5678);
    check("wr_we_c3", {31'd0, bus_write_enable}, 32'd0);
    m1_req = 1'b0; m1_we = 1'b0;
    $display("txn m1 write addr=0010 data=aabbccdd mask=e");
    tick();

    // ---- Simultaneous requests right after reset ----
    do_reset();
    m0_addr = 16'h0100; m1_addr = 16'h0200; m0_we = 1'b0; m1_we = 1'b0;
    m0_req = 1'b1; m1_req = 1'b1;
    d0 = -1; d1 = -1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) check("tie_first_addr", {16'd0, bus_address}, 32'h0000_0100);
      if (c == 5) check("tie_second_addr", {16'd0, bus_address}, 32'h0000_0200);
      if (m0_done) begin d0 = c; m0_req = 1'b0; end
      if (m1_done) begin d1 = c; m1_req = 1'b0; end
    end
    check("tie_m0_done_cycle", d0, 32'd3);
    check("tie_m1_done_cycle", d1, 32'd7);
    $display("txn tie m0 done at %0d, m1 done at %0d", d0, d1);

    // ---- Both held for six transactions: strict alternation ----
    m0_req = 1'b1; m1_req = 1'b1;
    n = 0;
    for (int c = 1; c <= 40 && n < 6; c++) begin
      tick();
      check("alt_single_done", {31'd0, m0_done & m1_done}, 32'd0);
      if (m0_done || m1_done) begin
        order[n] = m1_done ? 1 : 0;
        when[n] = c;
        $display("txn alt #%0d master %0d at cycle %0d", n, order[n], c);
        n++;
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    check("alt_count", n, 32'd6);
    for (int i = 0; i < n; i++) begin
      check("alt_order", order[i], i % 2);
      if (i > 0) check("alt_gap", when[i] - when[i-1], 32'd4);
    end
    tick();
    tick();

    // ---- Address change during ACCESS is ignored ----
    m0_addr = 16'h4000; m0_req = 1'b1;
    tick();
    m0_addr = 16'h5000;
    tick();
    check("hold_addr", {16'd0, bus_address}, 32'h0000_4000);
    tick();
    check("hold_done", {31'd0, m0_done}, 32'd1);
    m0_req = 1'b0;
    $display("txn m0 read with addr change, bus addr=%h", bus_address);
    tick();

    // ---- Reset mid-ACCESS ----
    m0_we = 1'b1; m0_addr = 16'h4000; m0_wdata = 32'h0BAD_F00D; m0_wmask = 4'h0;
    m0_req = 1'b1;
    tick();
    check("mid_en_before", {31'd0, bus_enable}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_en_async", {31'd0, bus_enable}, 32'd0);
    check("mid_we_async", {31'd0, bus_write_enable}, 32'd0);
    check("mid_rdata", rdata, 32'd0);
    tick();
    check("mid_no_done", {30'd0, m1_done, m0_done}, 32'd0);
    tick();
    check("mid_no_done2", {30'd0, m1_done, m0_done}, 32'd0);
    m1_addr = 16'h0200; m1_req = 1'b1;
    reset_n = 1'b1;
    tick();
    check("post_rst_addr", {16'd0, bus_address}, 32'h0000_4000);
    check("post_rst_we", {31'd0, bus_write_enable}, 32'd1);
    $display("txn reset mid-access, first grant addr=%h", bus_address);
    m0_req = 1'b0; m1_req = 1'b0;
    tick();
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
